// File: rtl/debounce_onehot.sv
// debounce_onehot: front end for the 4-to-2 encoder.
// Synchronises and debounces four raw key lines, latches each debounced
// press as a pending request, and issues requests one at a time as a
// registered one-hot code on Y3..Y0, each code followed by a zero gap.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   key_in   - raw asynchronous key lines, bit i maps to Yi
//   Y0..Y3   - one-hot request to the encoder (registered)
//   valid    - high exactly while one of Y3..Y0 is high (registered)
//   pending  - latched, not-yet-issued requests (registered)
module debounce_onehot #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    output logic       Y0,
    output logic       Y1,
    output logic       Y2,
    output logic       Y3,
    output logic       valid,
    output logic [3:0] pending
);

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W   = 8;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] stable_q;
    logic [NUM_KEYS-1:0] stable_prev_q;
    logic [CNT_W-1:0]    db_cnt_q [NUM_KEYS];

    logic [NUM_KEYS-1:0] pending_q;
    logic [NUM_KEYS-1:0] y_q;
    logic                valid_q;
    logic [HOLD_W-1:0]   hold_q;
    state_t              state_q;

    logic [NUM_KEYS-1:0] y_d;
    logic                valid_d;
    logic [HOLD_W-1:0]   hold_d;
    state_t              state_d;

    logic [NUM_KEYS-1:0] press_c;
    logic [NUM_KEYS-1:0] sel_c;
    logic [NUM_KEYS-1:0] clr_c;

    // Two-flop synchroniser and per-key debounce counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= key_in;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < int'(NUM_KEYS); i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == CNT_LAST) begin
                    stable_q[i] <= ~stable_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced rising edge marks a new press.
    assign press_c = stable_q & ~stable_prev_q;

    // Highest pending index wins (Y3 over Y0).
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (pending_q[i]) begin
                sel_c    = '0;
                sel_c[i] = 1'b1;
            end
        end
    end

    // Issue FSM: next state and registered-output next values.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        y_d     = y_q;
        valid_d = valid_q;
        clr_c   = '0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    y_d     = sel_c;
                    valid_d = 1'b1;
                    clr_c   = sel_c;
                    hold_d  = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    y_d     = '0;
                    valid_d = 1'b0;
                    state_d = GAP;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            GAP: begin
                y_d     = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                y_d     = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, outputs and pending requests; a new press beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            pending_q <= (pending_q & ~clr_c) | press_c;
        end
    end

    assign {Y3, Y2, Y1, Y0} = y_q;
    assign valid            = valid_q;
    assign pending          = pending_q;

endmodule

// File: tb/tb_debounce_onehot.sv
// tb_debounce_onehot: directed self-checking bench for debounce_onehot
// with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=3. Edge 0 is the first rising
// edge that samples a new key level; values are sampled 1 ns after edges.
module tb_debounce_onehot;

    localparam int unsigned DB = 4;
    localparam int unsigned HC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'b0000;
    logic       y0, y1, y2, y3;
    logic       valid;
    logic [3:0] pending;
    logic [3:0] y;
    logic       mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    assign y = {y3, y2, y1, y0};

    always #5 clk = ~clk;

    debounce_onehot #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .Y0     (y0),
        .Y1     (y1),
        .Y2     (y2),
        .Y3     (y3),
        .valid  (valid),
        .pending(pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release all keys and let everything drain back to quiet.
    task automatic settle();
        key_in = 4'b0000;
        repeat (16) tick();
        check("settle_pend", 32'(pending), 32'(0));
        check("settle_y", 32'(y), 32'(0));
    endtask

    // Output invariant: at most one Y high and valid tracks it.
    always @(negedge clk) begin
        if (mon_en) begin
            check("inv_popcnt", 32'($countones(y) <= 1), 32'(1));
            check("inv_valid", 32'(valid), 32'(|y));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] ey;
        logic [3:0] ep;
        int         highs;

        // Reset held with all keys pressed.
        rst_n  = 1'b0;
        key_in = 4'b1111;
        mon_en = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick();
            check("rst_y", 32'(y), 32'(0));
            check("rst_valid", 32'(valid), 32'(0));
            check("rst_pend", 32'(pending), 32'(0));
        end
        key_in = 4'b0000;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_pend", 32'(pending), 32'(0));

        // Clean press of key 1.
        key_in = 4'b0010;
        for (int e = 0; e <= 10; e++) begin
            tick();
            ey = (e >= 7 && e <= 9) ? 4'b0010 : 4'b0000;
            ep = (e == 6) ? 4'b0010 : 4'b0000;
            check("clean_y", 32'(y), 32'(ey));
            check("clean_valid", 32'(valid), 32'(ey != 4'b0000));
            check("clean_pend", 32'(pending), 32'(ep));
        end
        settle();

        // Bounce on key 0: 1,0,1,0 then steady 1 (held).
        highs = 0;
        for (int e = 0; e <= 40; e++) begin
            key_in = (e < 4) ? ((e % 2 == 0) ? 4'b0001 : 4'b0000) : 4'b0001;
            tick();
            if (y[0]) highs++;
            if (e <= 14) begin
                ey = (e >= 11 && e <= 13) ? 4'b0001 : 4'b0000;
                ep = (e == 10) ? 4'b0001 : 4'b0000;
                check("bounce_y", 32'(y), 32'(ey));
                check("bounce_pend", 32'(pending), 32'(ep));
            end
        end
        check("bounce_y0_cycles", 32'(highs), 32'(3));
        settle();

        // Simultaneous press of keys 3 and 0.
        key_in = 4'b1001;
        for (int e = 0; e <= 15; e++) begin
            tick();
            if (e >= 7 && e <= 9)       ey = 4'b1000;
            else if (e >= 12 && e <= 14) ey = 4'b0001;
            else                         ey = 4'b0000;
            if (e == 6)                 ep = 4'b1001;
            else if (e >= 7 && e <= 11) ep = 4'b0001;
            else                        ep = 4'b0000;
            check("simul_y", 32'(y), 32'(ey));
            check("simul_pend", 32'(pending), 32'(ep));
        end
        settle();

        // Key 3 held so key 2 issues later; key 2 released and re-pressed
        // so its second press lands while Y2 is held.
        for (int e = 0; e <= 21; e++) begin
            if (e < 4)      key_in = 4'b1100;
            else if (e < 8) key_in = 4'b1000;
            else            key_in = 4'b1100;
            tick();
            if (e >= 7 && e <= 9)                                ey = 4'b1000;
            else if ((e >= 12 && e <= 14) || (e >= 17 && e <= 19)) ey = 4'b0100;
            else                                                  ey = 4'b0000;
            if (e == 6)                                          ep = 4'b1100;
            else if ((e >= 7 && e <= 11) || (e >= 14 && e <= 16)) ep = 4'b0100;
            else                                                  ep = 4'b0000;
            check("repress_y", 32'(y), 32'(ey));
            check("repress_pend", 32'(pending), 32'(ep));
        end
        settle();

        // Reset mid-HOLD while key 0 is still pending.
        key_in = 4'b0011;
        for (int e = 0; e <= 7; e++) tick();
        check("midrst_pre_y", 32'(y), 32'(4'b0010));
        check("midrst_pre_pend", 32'(pending), 32'(4'b0001));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_y", 32'(y), 32'(0));
        check("midrst_valid", 32'(valid), 32'(0));
        check("midrst_pend", 32'(pending), 32'(0));
        key_in = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        highs = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (y != 4'b0000 || pending != 4'b0000) highs++;
        end
        check("midrst_no_stale", 32'(highs), 32'(0));

        // Fresh press after the reset issues normally.
        key_in = 4'b0001;
        for (int e = 0; e <= 10; e++) begin
            tick();
            ey = (e >= 7 && e <= 9) ? 4'b0001 : 4'b0000;
            check("after_rst_y", 32'(y), 32'(ey));
        end
        settle();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
